// File: rtl/blake2_block_feeder.sv
// blake2_block_feeder
//   Stream-to-block front end for blake2_core. Packs a valid/ready word
//   stream into BLOCK_WIDTH-bit blocks, buffers up to MAX_BLOCKS blocks and
//   sequences the core's init / next / final_block / data_length handshake,
//   including back-to-back messages.
//
// Ports
//   clk, reset_n        : clock, asynchronous active-low reset
//   valid_in, ready_out : word handshake (accept on valid_in & ready_out)
//   din                 : message word, byte 0 in bits [7:0]
//   last_in, last_bytes : end of message, valid bytes in last word (0 = full)
//   init, next          : one-cycle command pulses to the core
//   final_block         : head block is the last block of its message
//   block, data_length  : FIFO head block and cumulative byte count (0 when empty)
//   hash_ready          : core ready
//   digest_valid        : core digest valid
//   hash_started        : pulses with init
//   hash_done           : pulses when the digest of the message is valid
//   buf_empty, buf_full : FIFO status
module blake2_block_feeder #(
  parameter int BUS_WIDTH   = 64,
  parameter int BLOCK_WIDTH = 1024,
  parameter int MAX_BLOCKS  = 4,
  parameter int DATA_LENGTH = 128
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           valid_in,
  input  logic [BUS_WIDTH-1:0]           din,
  input  logic                           last_in,
  input  logic [$clog2(BUS_WIDTH/8):0]   last_bytes,
  output logic                           ready_out,
  output logic                           init,
  output logic                           next,
  output logic                           final_block,
  output logic [BLOCK_WIDTH-1:0]         block,
  output logic [DATA_LENGTH-1:0]         data_length,
  input  logic                           hash_ready,
  input  logic                           digest_valid,
  output logic                           hash_started,
  output logic                           hash_done,
  output logic                           buf_empty,
  output logic                           buf_full
);

  localparam int WPB   = BLOCK_WIDTH / BUS_WIDTH;
  localparam int BPW   = BUS_WIDTH / 8;
  localparam int LB_W  = $clog2(BPW) + 1;
  localparam int IDX_W = (WPB > 1) ? $clog2(WPB) : 1;
  localparam int PTR_W = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;
  localparam int CNT_W = $clog2(MAX_BLOCKS + 1);

  typedef enum logic [2:0] {IDLE, WAIT_INIT, FEED, WAIT_BLK, WAIT_DIG} state_t;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(MAX_BLOCKS - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------- packer ----------------
  logic [IDX_W-1:0]       widx;
  logic [BLOCK_WIDTH-1:0] asm_blk;
  logic [DATA_LENGTH-1:0] byte_cnt;
  logic [LB_W-1:0]        nbytes;
  logic [BUS_WIDTH-1:0]   word_masked;
  logic [BLOCK_WIDTH-1:0] blk_new;
  logic [DATA_LENGTH-1:0] len_new;
  logic                   accept, push, pop;

  assign accept  = valid_in & ready_out;
  assign push    = accept & ((widx == IDX_W'(WPB - 1)) | last_in);
  assign nbytes  = (last_in && last_bytes != '0) ? last_bytes : LB_W'(BPW);
  assign len_new = byte_cnt + DATA_LENGTH'(nbytes);

  always_comb begin
    word_masked = din;
    for (int b = 0; b < BPW; b++)
      if (b >= int'(nbytes)) word_masked[b*8 +: 8] = 8'h00;
  end

  // Only words below the current index come from the assembly register, so
  // stale contents from an earlier block never leak and it needs no reset.
  always_comb begin
    blk_new = '0;
    for (int j = 0; j < WPB; j++) begin
      if (j < int'(widx))
        blk_new[j*BUS_WIDTH +: BUS_WIDTH] = asm_blk[j*BUS_WIDTH +: BUS_WIDTH];
      else if (j == int'(widx))
        blk_new[j*BUS_WIDTH +: BUS_WIDTH] = word_masked;
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !push) asm_blk[widx*BUS_WIDTH +: BUS_WIDTH] <= word_masked;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      widx     <= '0;
      byte_cnt <= '0;
    end else if (accept) begin
      widx     <= push ? '0 : widx + 1'b1;
      byte_cnt <= last_in ? '0 : len_new;
    end
  end

  // ---------------- block FIFO ----------------
  logic [BLOCK_WIDTH-1:0] fifo_blk  [MAX_BLOCKS];
  logic [DATA_LENGTH-1:0] fifo_len  [MAX_BLOCKS];
  logic                   fifo_last [MAX_BLOCKS];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_blk[wr_ptr]  <= blk_new;
      fifo_len[wr_ptr]  <= len_new;
      fifo_last[wr_ptr] <= last_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign buf_empty   = (count == '0);
  assign buf_full    = (count == CNT_W'(MAX_BLOCKS));
  assign ready_out   = !buf_full;
  assign block       = buf_empty ? '0 : fifo_blk[rd_ptr];
  assign data_length = buf_empty ? '0 : fifo_len[rd_ptr];
  assign final_block = buf_empty ? 1'b0 : fifo_last[rd_ptr];

  // ---------------- sequencer ----------------
  state_t state, state_nx;
  logic   settle;  // high on the first cycle of a state: core ready is stale then

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= IDLE;
      settle <= 1'b0;
    end else begin
      state  <= state_nx;
      settle <= (state_nx != state);
    end
  end

  always_comb begin
    state_nx  = state;
    init      = 1'b0;
    next      = 1'b0;
    hash_done = 1'b0;
    pop       = 1'b0;
    case (state)
      IDLE: if (!buf_empty) begin
        init     = 1'b1;
        state_nx = WAIT_INIT;
      end
      WAIT_INIT: if (!settle && hash_ready) state_nx = FEED;
      FEED: if (!buf_empty) begin
        next     = 1'b1;
        state_nx = WAIT_BLK;
      end
      WAIT_BLK: if (!settle && hash_ready) begin
        pop      = 1'b1;
        state_nx = final_block ? WAIT_DIG : FEED;
      end
      WAIT_DIG: if (digest_valid) begin
        hash_done = 1'b1;
        state_nx  = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign hash_started = init;

endmodule

// File: tb/tb_blake2_block_feeder.sv
// tb_blake2_block_feeder
//   Self-checking bench for blake2_block_feeder with default parameters.
//   A small core model answers init/next with a busy period; a scoreboard
//   holds the expected {block, final flag, length} for every block pushed and
//   compares it at each next pulse. Whole messages come from a table; the
//   multi-cycle corner cases are written out by hand.
module tb_blake2_block_feeder;

  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          valid_in;
  logic [63:0]   din;
  logic          last_in;
  logic [3:0]    last_bytes;
  logic          ready_out, init, next, final_block;
  logic [1023:0] block;
  logic [127:0]  data_length;
  logic          hash_ready, digest_valid;
  logic          hash_started, hash_done, buf_empty, buf_full;

  blake2_block_feeder dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .din(din),
    .last_in(last_in), .last_bytes(last_bytes), .ready_out(ready_out),
    .init(init), .next(next), .final_block(final_block), .block(block),
    .data_length(data_length), .hash_ready(hash_ready),
    .digest_valid(digest_valid), .hash_started(hash_started),
    .hash_done(hash_done), .buf_empty(buf_empty), .buf_full(buf_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1023:0] blk;
    logic          last;
    logic [127:0]  len;
  } exp_t;

  typedef struct {
    int nwords;
    int lb;
    bit ones;
    int exp_blocks;
    int exp_len;
  } vec_t;

  exp_t sb[$];
  int   checks = 0, errors = 0;
  int   cyc = 0;
  int   n_init = 0, n_next = 0, n_done = 0;
  int   init_cyc[$], done_cyc[$];
  int   last_init = 0, gap = 0;
  bit   after_init = 0;
  bit   hold = 0;
  logic [1023:0] last_blk;
  logic [127:0]  last_len;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_blk(input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      for (int i = 0; i < 16; i++)
        if (act[i*64 +: 64] !== exp[i*64 +: 64]) begin
          $display("FAIL block word %0d: got %h expected %h", i, act[i*64 +: 64], exp[i*64 +: 64]);
          break;
        end
    end
  endtask

  // Core model: drops ready for LAT cycles after each command, digest_valid
  // is a level raised when a final block completes and cleared by init.
  initial begin
    int  busy = 0;
    bit  pend = 0;
    hash_ready   = 1'b1;
    digest_valid = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        hash_ready = 1'b1; digest_valid = 1'b0; busy = 0; pend = 0;
      end else if (init) begin
        hash_ready = 1'b0; digest_valid = 1'b0; busy = LAT; pend = 0;
      end else if (next) begin
        hash_ready = 1'b0; busy = LAT; pend = final_block;
      end else if (busy > 0) begin
        busy--;
      end else if (!hold && !hash_ready) begin
        hash_ready = 1'b1;
        if (pend) digest_valid = 1'b1;
        pend = 0;
      end
    end
  end

  // Monitor / scoreboard consumer.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (init) begin
        n_init++;
        init_cyc.push_back(cyc);
        last_init  = cyc;
        after_init = 1;
        chk("hash_started_with_init", hash_started, 1'b1);
      end
      if (next) begin
        n_next++;
        if (after_init) begin
          gap = cyc - last_init;
          after_init = 0;
        end
        last_blk = block;
        last_len = data_length;
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_next: got next with length %0d, expected no block", data_length);
        end else begin
          e = sb.pop_front();
          chk("final_block", final_block, e.last);
          chk("data_length", data_length, e.len);
          chk_blk(block, e.blk);
        end
      end
      if (hash_done) begin
        n_done++;
        done_cyc.push_back(cyc);
      end
    end
  end

  // Sends words 0..nsend-1 of an nwords message; starts and ends on a negedge.
  task automatic send_msg(input int nwords, input int lb, input bit ones, input int nsend);
    logic [1023:0] m_blk = '0;
    logic [127:0]  m_len = '0;
    int            m_k = 0;
    logic [63:0]   w;
    int            nb;
    int            t;
    exp_t          e;
    for (int i = 0; i < nsend; i++) begin
      w          = ones ? 64'hFFFF_FFFF_FFFF_FFFF : 64'(i + 1);
      valid_in   = 1'b1;
      din        = w;
      last_in    = (i == nwords - 1);
      last_bytes = last_in ? 4'(lb) : 4'd0;
      t = 0;
      while (!ready_out && t < 3000) begin
        @(negedge clk);
        t++;
      end
      if (!ready_out) begin
        checks++; errors++;
        $display("FAIL ready_timeout: word %0d still stalled, expected acceptance", i);
        valid_in = 1'b0;
        return;
      end
      nb = (last_in && lb != 0) ? lb : 8;
      if (nb < 8) w = w & ((64'd1 << (8 * nb)) - 64'd1);
      m_blk[m_k*64 +: 64] = w;
      m_len = m_len + 128'(nb);
      if (m_k == 15 || last_in) begin
        e.blk = m_blk; e.last = last_in; e.len = m_len;
        sb.push_back(e);
        m_blk = '0;
        m_k   = 0;
      end else begin
        m_k++;
      end
      @(negedge clk);
    end
    valid_in = 1'b0;
    last_in  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t = 0;
    while (n_done < target && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("hash_done_reached", 128'(n_done >= target), 128'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_init"}, init, 1'b0);
    chk({tag, "_next"}, next, 1'b0);
    chk({tag, "_final"}, final_block, 1'b0);
    chk({tag, "_started"}, hash_started, 1'b0);
    chk({tag, "_done"}, hash_done, 1'b0);
    chk({tag, "_block"}, 128'(block == '0), 128'd1);
    chk({tag, "_len"}, data_length, 128'd0);
    chk({tag, "_empty"}, buf_empty, 1'b1);
    chk({tag, "_full"}, buf_full, 1'b0);
    chk({tag, "_ready"}, ready_out, 1'b1);
  endtask

  initial begin
    vec_t vecs[5];
    int   n0, d0, i0;

    vecs[0] = '{nwords: 16, lb: 0, ones: 0, exp_blocks: 1, exp_len: 128};
    vecs[1] = '{nwords: 64, lb: 0, ones: 0, exp_blocks: 4, exp_len: 512};
    vecs[2] = '{nwords: 18, lb: 3, ones: 1, exp_blocks: 2, exp_len: 139};
    vecs[3] = '{nwords: 5,  lb: 1, ones: 0, exp_blocks: 1, exp_len: 33};
    vecs[4] = '{nwords: 16, lb: 5, ones: 0, exp_blocks: 1, exp_len: 125};

    reset_n = 1'b0; valid_in = 1'b0; din = '0; last_in = 1'b0; last_bytes = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Table-driven whole messages.
    for (int i = 0; i < 5; i++) begin
      n0 = n_next; d0 = n_done;
      send_msg(vecs[i].nwords, vecs[i].lb, vecs[i].ones, vecs[i].nwords);
      wait_done(d0 + 1);
      chk("blocks_per_msg", 128'(n_next - n0), 128'(vecs[i].exp_blocks));
      chk("final_length", last_len, 128'(vecs[i].exp_len));
      chk("scoreboard_drained", 128'(sb.size()), 128'd0);
      chk("init_next_gap_ok", 128'(gap >= 2), 128'd1);
      if (vecs[i].nwords == 18) begin
        chk("tail_word1", last_blk[64 +: 64], 128'h0000_0000_00FF_FFFF);
        chk("tail_words2_15_zero", 128'(last_blk[1023:128] == '0), 128'd1);
        chk("tail_word0", last_blk[63:0], 128'hFFFF_FFFF_FFFF_FFFF);
      end
      @(negedge clk);
    end

    // Backpressure: core held after init while 80 words (5 blocks) stream in.
    hold = 1; n0 = n_next; d0 = n_done;
    fork
      send_msg(80, 0, 0, 80);
      begin
        int t = 0;
        while (!buf_full && t < 500) begin
          @(negedge clk);
          t++;
        end
        chk("bp_buf_full", buf_full, 1'b1);
        chk("bp_ready_low", ready_out, 1'b0);
        repeat (10) @(negedge clk);
        chk("bp_still_full", buf_full, 1'b1);
        chk("bp_no_next_while_held", 128'(n_next - n0), 128'd0);
        hold = 0;
      end
    join
    wait_done(d0 + 1);
    chk("bp_blocks", 128'(n_next - n0), 128'd5);
    chk("bp_length", last_len, 128'd640);
    chk("bp_scoreboard_drained", 128'(sb.size()), 128'd0);
    @(negedge clk);

    // Back-to-back: second message queued before the first digest is ready.
    hold = 1; n0 = n_init; d0 = n_done;
    init_cyc.delete(); done_cyc.delete();
    send_msg(16, 0, 0, 16);
    send_msg(16, 0, 1, 16);
    hold = 0;
    wait_done(d0 + 2);
    chk("b2b_inits", 128'(n_init - n0), 128'd2);
    if (init_cyc.size() >= 2 && done_cyc.size() >= 1)
      chk("b2b_init_after_done", 128'(init_cyc[1] - done_cyc[0]), 128'd1);
    else
      chk("b2b_event_count", 128'(init_cyc.size()), 128'd2);
    chk("b2b_length", last_len, 128'd128);
    @(negedge clk);

    // Reset in the middle of block 3 of a 4-block message.
    hold = 1;
    send_msg(64, 0, 0, 40);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    sb.delete();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    hold = 0;
    @(negedge clk);
    i0 = n_init; n0 = n_next; d0 = n_done;
    send_msg(16, 0, 0, 16);
    wait_done(d0 + 1);
    chk("post_reset_inits", 128'(n_init - i0), 128'd1);
    chk("post_reset_blocks", 128'(n_next - n0), 128'd1);
    chk("post_reset_length", last_len, 128'd128);
    chk("post_reset_drained", 128'(sb.size()), 128'd0);
    repeat (5) @(negedge clk);
    chk("post_reset_idle_empty", buf_empty, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
